// File: rtl/lcd_frame_formatter_pkg.sv
// lcd_fmt_pkg: FSM states, HD44780 cursor commands and ASCII helpers for the frame formatter.
package lcd_fmt_pkg;

    typedef enum logic [1:0] {IDLE, CMD, CHAR} state_t;

    localparam logic [7:0] CMD_LINE0 = 8'h80;
    localparam logic [7:0] CMD_LINE1 = 8'hC0;

    localparam logic [7:0] ASC_SP   = 8'h20;
    localparam logic [7:0] ASC_EQ   = 8'h3D;
    localparam logic [7:0] ASC_DASH = 8'h2D;
    localparam logic [7:0] ASC_W    = 8'h57;
    localparam logic [7:0] ASC_R    = 8'h52;
    localparam logic [7:0] ASC_X    = 8'h78;

    function automatic logic [7:0] hex2ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [4:0] dec_tens_val(input logic [4:0] v);
        return (v >= 5'd30) ? 5'd30 : (v >= 5'd20) ? 5'd20 : (v >= 5'd10) ? 5'd10 : 5'd0;
    endfunction

    function automatic logic [7:0] dec_tens(input logic [4:0] v);
        return (v >= 5'd30) ? 8'h33 : (v >= 5'd20) ? 8'h32 : (v >= 5'd10) ? 8'h31 : 8'h30;
    endfunction

    function automatic logic [7:0] dec_ones(input logic [4:0] v);
        return 8'h30 + 8'(v - dec_tens_val(v));
    endfunction

endpackage

// File: rtl/lcd_frame_formatter_if.sv
// lcd_char_if: byte stream from the frame formatter to the character-LCD driver.
interface lcd_char_if;

    logic [7:0] char_data;
    logic       char_is_cmd;
    logic       char_valid;
    logic       char_ready;
    logic       frame_busy;
    logic       frame_done;

    modport master (
        output char_data, char_is_cmd, char_valid, frame_busy, frame_done,
        input  char_ready
    );

    modport slave (
        input  char_data, char_is_cmd, char_valid, frame_busy, frame_done,
        output char_ready
    );

endinterface

// File: rtl/lcd_frame_formatter_char_select.sv
// lcd_char_select: maps snapshot, page, line and column to the ASCII byte shown there.
module lcd_char_select
    import lcd_fmt_pkg::*;
(
    input  logic        i_page,
    input  logic        i_line,
    input  logic [3:0]  i_col,
    input  logic [7:0]  i_pc,
    input  logic [31:0] i_instr,
    input  logic [7:0]  i_src_a,
    input  logic [7:0]  i_src_b,
    input  logic [7:0]  i_alu,
    input  logic        i_mem_write,
    input  logic        i_reg_write,
    input  logic [4:0]  i_base,
    input  logic [7:0]  i_win [4],
    output logic [7:0]  o_char
);

    logic [4:0] w_idx0;
    logic [4:0] w_idx1;
    logic [7:0] w_v0;
    logic [7:0] w_v1;
    logic [3:0] w_nib;
    logic [7:0] w_dp;
    logic [7:0] w_rg;

    assign w_idx0 = i_base + {3'b000, i_line, 1'b0};
    assign w_idx1 = w_idx0 + 5'd1;
    assign w_v0   = i_win[{i_line, 1'b0}];
    assign w_v1   = i_win[{i_line, 1'b1}];
    // columns 8..15 of line 0 walk the instruction from its top nibble down
    assign w_nib  = i_instr[{~i_col[2:0], 2'b00} +: 4];

    always_comb begin
        w_dp = ASC_SP;
        if (!i_line) begin
            case (i_col)
                4'd0:    w_dp = "P";
                4'd1:    w_dp = "C";
                4'd2:    w_dp = ASC_EQ;
                4'd3:    w_dp = hex2ascii(i_pc[7:4]);
                4'd4:    w_dp = hex2ascii(i_pc[3:0]);
                4'd6:    w_dp = "I";
                4'd7:    w_dp = ASC_EQ;
                default: w_dp = i_col[3] ? hex2ascii(w_nib) : ASC_SP;
            endcase
        end else begin
            case (i_col)
                4'd0:    w_dp = "A";
                4'd1:    w_dp = ASC_EQ;
                4'd2:    w_dp = hex2ascii(i_src_a[7:4]);
                4'd3:    w_dp = hex2ascii(i_src_a[3:0]);
                4'd5:    w_dp = "B";
                4'd6:    w_dp = ASC_EQ;
                4'd7:    w_dp = hex2ascii(i_src_b[7:4]);
                4'd8:    w_dp = hex2ascii(i_src_b[3:0]);
                4'd10:   w_dp = "Y";
                4'd11:   w_dp = ASC_EQ;
                4'd12:   w_dp = hex2ascii(i_alu[7:4]);
                4'd13:   w_dp = hex2ascii(i_alu[3:0]);
                4'd14:   w_dp = i_mem_write ? ASC_W : ASC_DASH;
                4'd15:   w_dp = i_reg_write ? ASC_R : ASC_DASH;
                default: w_dp = ASC_SP;
            endcase
        end
    end

    always_comb begin
        w_rg = ASC_SP;
        case (i_col)
            4'd0:    w_rg = ASC_X;
            4'd1:    w_rg = dec_tens(w_idx0);
            4'd2:    w_rg = dec_ones(w_idx0);
            4'd3:    w_rg = ASC_EQ;
            4'd4:    w_rg = hex2ascii(w_v0[7:4]);
            4'd5:    w_rg = hex2ascii(w_v0[3:0]);
            4'd7:    w_rg = ASC_X;
            4'd8:    w_rg = dec_tens(w_idx1);
            4'd9:    w_rg = dec_ones(w_idx1);
            4'd10:   w_rg = ASC_EQ;
            4'd11:   w_rg = hex2ascii(w_v1[7:4]);
            4'd12:   w_rg = hex2ascii(w_v1[3:0]);
            default: w_rg = ASC_SP;
        endcase
    end

    assign o_char = i_page ? w_rg : w_dp;

endmodule

// File: rtl/lcd_frame_formatter.sv
// lcd_frame_formatter: periodically snapshots the processor display bus and streams
// one 2x16 HD44780 frame (cursor commands + ASCII) over a valid/ready handshake.
module lcd_frame_formatter
    import lcd_fmt_pkg::*;
#(
    parameter int NBITS          = 8,
    parameter int NREGS          = 32,
    parameter int NINSTR_BITS    = 32,
    parameter int REFRESH_CYCLES = 1000
) (
    input  logic                   clk_2,
    input  logic                   reset_n,
    input  logic                   page_sel,
    input  logic [4:0]             reg_base,
    input  logic [NBITS-1:0]       lcd_pc,
    input  logic [NBITS-1:0]       lcd_SrcA,
    input  logic [NBITS-1:0]       lcd_SrcB,
    input  logic [NBITS-1:0]       lcd_ALUResult,
    input  logic [NINSTR_BITS-1:0] lcd_instruction,
    input  logic                   lcd_MemWrite,
    input  logic                   lcd_RegWrite,
    input  logic [NBITS-1:0]       lcd_registrador [NREGS],
    lcd_char_if.master             char_if
);

    localparam int CW = $clog2(REFRESH_CYCLES);

    logic [CW-1:0]          r_cnt;
    state_t                 r_state;
    logic                   r_line;
    logic [3:0]             r_col;
    logic                   r_pending;
    logic [7:0]             r_data;
    logic                   r_is_cmd;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_done;

    logic                   r_page;
    logic [4:0]             r_base;
    logic [NBITS-1:0]       r_pc;
    logic [NBITS-1:0]       r_a;
    logic [NBITS-1:0]       r_b;
    logic [NBITS-1:0]       r_y;
    logic [NINSTR_BITS-1:0] r_instr;
    logic                   r_mw;
    logic                   r_rw;
    logic [NBITS-1:0]       r_win [4];

    state_t                 w_state;
    logic                   w_line;
    logic [3:0]             w_col;
    logic                   w_pending;
    logic                   w_load;
    logic                   w_last;
    logic                   w_tick;
    logic                   w_accept;
    logic [7:0]             w_char;
    logic [7:0]             w_data;
    logic [7:0]             w_win8 [4];

    assign w_tick   = (r_cnt == CW'(REFRESH_CYCLES - 1));
    assign w_accept = r_valid & char_if.char_ready;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else          r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
    end

    always_comb begin
        w_state = r_state;
        w_line  = r_line;
        w_col   = r_col;
        w_load  = 1'b0;
        w_last  = 1'b0;
        case (r_state)
            IDLE: if (w_tick) begin
                w_state = CMD;
                w_line  = 1'b0;
                w_col   = 4'd0;
                w_load  = 1'b1;
            end
            CMD: if (w_accept) begin
                w_state = CHAR;
                w_col   = 4'd0;
            end
            CHAR: if (w_accept) begin
                if (r_col != 4'd15) begin
                    w_col = r_col + 4'd1;
                end else if (!r_line) begin
                    w_state = CMD;
                    w_line  = 1'b1;
                end else begin
                    // a tick landing on the final accept counts as pending
                    w_last  = 1'b1;
                    w_load  = r_pending | w_tick;
                    w_state = (r_pending | w_tick) ? CMD : IDLE;
                    w_line  = 1'b0;
                    w_col   = 4'd0;
                end
            end
            default: w_state = IDLE;
        endcase
        w_pending = w_last ? 1'b0 : (r_pending | (w_tick & (r_state != IDLE)));
        w_data    = (w_state == CMD)  ? (w_line ? CMD_LINE1 : CMD_LINE0) :
                    (w_state == CHAR) ? w_char : 8'h00;
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_line    <= 1'b0;
            r_col     <= 4'd0;
            r_pending <= 1'b0;
            r_data    <= 8'h00;
            r_is_cmd  <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_line    <= w_line;
            r_col     <= w_col;
            r_pending <= w_pending;
            r_data    <= w_data;
            r_is_cmd  <= (w_state == CMD);
            r_valid   <= (w_state != IDLE);
            r_busy    <= (w_state != IDLE);
            r_done    <= w_last;
        end
    end

    // only the four windowed registers are kept; reg_base is frozen with them
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_page  <= 1'b0;
            r_base  <= 5'd0;
            r_pc    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_y     <= '0;
            r_instr <= '0;
            r_mw    <= 1'b0;
            r_rw    <= 1'b0;
            for (int k = 0; k < 4; k++) r_win[k] <= '0;
        end else if (w_load) begin
            r_page  <= page_sel;
            r_base  <= reg_base & 5'b11100;
            r_pc    <= lcd_pc;
            r_a     <= lcd_SrcA;
            r_b     <= lcd_SrcB;
            r_y     <= lcd_ALUResult;
            r_instr <= lcd_instruction;
            r_mw    <= lcd_MemWrite;
            r_rw    <= lcd_RegWrite;
            for (int k = 0; k < 4; k++) r_win[k] <= lcd_registrador[{reg_base[4:2], 2'(k)}];
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) w_win8[k] = 8'(r_win[k]);
    end

    lcd_char_select u_sel (
        .i_page      (r_page),
        .i_line      (w_line),
        .i_col       (w_col),
        .i_pc        (8'(r_pc)),
        .i_instr     (32'(r_instr)),
        .i_src_a     (8'(r_a)),
        .i_src_b     (8'(r_b)),
        .i_alu       (8'(r_y)),
        .i_mem_write (r_mw),
        .i_reg_write (r_rw),
        .i_base      (r_base),
        .i_win       (w_win8),
        .o_char      (w_char)
    );

    assign char_if.char_data   = r_data;
    assign char_if.char_is_cmd = r_is_cmd;
    assign char_if.char_valid  = r_valid;
    assign char_if.frame_busy  = r_busy;
    assign char_if.frame_done  = r_done;

endmodule
